// File: rtl/touch_key_ctrl.sv
// Touch-panel key sequencer: hit-tests registered touch samples against a fixed key grid,
// debounces press/release, and issues press and auto-repeat events through a one-entry holding register.
module touch_key_ctrl #(
  parameter int DEB_CYCLES    = 4,
  parameter int REPEAT_DELAY  = 50,
  parameter int REPEAT_PERIOD = 20,
  parameter int KEY_X0        = 0,
  parameter int KEY_Y0        = 0,
  parameter int KEY_W         = 200,
  parameter int KEY_H         = 160,
  parameter int COLS          = 4,
  parameter int ROWS          = 3
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [31:0] touch_data,
  input  logic        key_ready,
  output logic        key_valid,
  output logic [3:0]  key_id,
  output logic        key_repeat,
  output logic        key_drop,
  output logic        touch_active,
  output logic [1:0]  dbg_state
);

  localparam int CMAX0 = (DEB_CYCLES > REPEAT_DELAY) ? DEB_CYCLES : REPEAT_DELAY;
  localparam int CMAX  = (CMAX0 > REPEAT_PERIOD) ? CMAX0 : REPEAT_PERIOD;
  localparam int CW    = $clog2(CMAX + 1);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_DEBOUNCE = 2'd1;
  localparam logic [1:0] S_HELD     = 2'd2;
  localparam logic [1:0] S_RELEASE  = 2'd3;

  logic [31:0]   touch_q;
  logic [1:0]    state, state_n;
  logic [CW-1:0] deb_cnt, deb_n, deb_inc;
  logic [CW-1:0] rep_cnt, rep_n, rep_inc, rep_tgt;
  logic [3:0]    cur_key, key_n, hit_key, emit_key;
  logic          first_rep, first_n;
  logic          hit, match, emit, emit_rep;
  logic          col_hit, row_hit;
  int            xi, yi, col_i, row_i;

  // Half-open cell test using boundary comparators only; the last matching cell wins (cells never overlap).
  always_comb begin
    xi      = {16'd0, touch_q[31:16]};
    yi      = {16'd0, touch_q[15:0]};
    col_hit = 1'b0;
    row_hit = 1'b0;
    col_i   = 0;
    row_i   = 0;
    for (int c = 0; c < COLS; c++) begin
      if (xi >= KEY_X0 + c * KEY_W && xi < KEY_X0 + (c + 1) * KEY_W) begin
        col_hit = 1'b1;
        col_i   = c;
      end
    end
    for (int r = 0; r < ROWS; r++) begin
      if (yi >= KEY_Y0 + r * KEY_H && yi < KEY_Y0 + (r + 1) * KEY_H) begin
        row_hit = 1'b1;
        row_i   = r;
      end
    end
    hit_key = 4'(row_i * COLS + col_i);
    hit     = (touch_q != 32'd0) && col_hit && row_hit;
    match   = hit && (hit_key == cur_key);
  end

  assign deb_inc  = deb_cnt + CW'(1);
  assign rep_inc  = rep_cnt + CW'(1);
  assign rep_tgt  = first_rep ? CW'(REPEAT_DELAY) : CW'(REPEAT_PERIOD);
  assign emit_key = (state == S_IDLE) ? hit_key : cur_key;

  always_comb begin
    state_n  = state;
    deb_n    = deb_cnt;
    rep_n    = rep_cnt;
    first_n  = first_rep;
    key_n    = cur_key;
    emit     = 1'b0;
    emit_rep = 1'b0;
    case (state)
      S_IDLE: begin
        if (hit) begin
          key_n = hit_key;
          deb_n = CW'(1);
          if (DEB_CYCLES == 1) begin
            emit    = 1'b1;
            rep_n   = '0;
            first_n = 1'b1;
            state_n = S_HELD;
          end else begin
            state_n = S_DEBOUNCE;
          end
        end
      end
      S_DEBOUNCE: begin
        if (match) begin
          deb_n = deb_inc;
          if (deb_inc == CW'(DEB_CYCLES)) begin
            emit    = 1'b1;
            rep_n   = '0;
            first_n = 1'b1;
            state_n = S_HELD;
          end
        end else begin
          state_n = S_IDLE;
        end
      end
      S_HELD: begin
        if (match) begin
          if (rep_inc == rep_tgt) begin
            emit     = 1'b1;
            emit_rep = 1'b1;
            rep_n    = '0;
            first_n  = 1'b0;
          end else begin
            rep_n = rep_inc;
          end
        end else begin
          // rep_cnt is left untouched so a bounce back into HELD resumes the repeat timing.
          deb_n   = CW'(1);
          state_n = (DEB_CYCLES == 1) ? S_IDLE : S_RELEASE;
        end
      end
      S_RELEASE: begin
        if (match) begin
          state_n = S_HELD;
        end else begin
          deb_n = deb_inc;
          if (deb_inc == CW'(DEB_CYCLES)) state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      touch_q   <= '0;
      state     <= S_IDLE;
      deb_cnt   <= '0;
      rep_cnt   <= '0;
      first_rep <= 1'b0;
      cur_key   <= '0;
    end else begin
      touch_q   <= touch_data;
      state     <= state_n;
      deb_cnt   <= deb_n;
      rep_cnt   <= rep_n;
      first_rep <= first_n;
      cur_key   <= key_n;
    end
  end

  // Handshake: an event is transferred on a rising edge where key_valid && key_ready; key_valid holds
  // with stable key_id/key_repeat until then. A new event may load on the transfer edge itself.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      key_valid  <= 1'b0;
      key_id     <= '0;
      key_repeat <= 1'b0;
      key_drop   <= 1'b0;
    end else begin
      key_drop <= 1'b0;
      if (emit) begin
        if (!key_valid || key_ready) begin
          key_valid  <= 1'b1;
          key_id     <= emit_key;
          key_repeat <= emit_rep;
        end else begin
          key_drop <= 1'b1;
        end
      end else if (key_valid && key_ready) begin
        key_valid <= 1'b0;
      end
    end
  end

  assign touch_active = (state == S_HELD) || (state == S_RELEASE);
  assign dbg_state    = state;

endmodule

// File: tb/tb_touch_key_ctrl.sv
// Bench for touch_key_ctrl: directed test-plan steps followed by random touch segments, all checked
// every cycle against a behavioural key/debounce/repeat model and an event scoreboard.
module tb_touch_key_ctrl;
  localparam int DEB  = 4;
  localparam int RDLY = 50;
  localparam int RPER = 20;
  localparam int X0   = 0;
  localparam int Y0   = 0;
  localparam int W    = 200;
  localparam int H    = 160;
  localparam int COLS = 4;
  localparam int ROWS = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] touch_data = '0;
  logic        key_ready = 1'b0;
  logic        key_valid, key_repeat, key_drop, touch_active;
  logic [3:0]  key_id;
  logic [1:0]  dbg_state;

  touch_key_ctrl #(
    .DEB_CYCLES(DEB), .REPEAT_DELAY(RDLY), .REPEAT_PERIOD(RPER),
    .KEY_X0(X0), .KEY_Y0(Y0), .KEY_W(W), .KEY_H(H), .COLS(COLS), .ROWS(ROWS)
  ) dut (
    .clk(clk), .rstn(rstn), .touch_data(touch_data), .key_ready(key_ready),
    .key_valid(key_valid), .key_id(key_id), .key_repeat(key_repeat),
    .key_drop(key_drop), .touch_active(touch_active), .dbg_state(dbg_state)
  );

  // clock
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int acc_cnt = 0;
  int drop_cnt = 0;
  int last_acc_id = -1;
  logic [4:0] exp_q[$];

  // behavioural model state
  logic [31:0] m_tq;
  bit m_pending, m_active, m_releasing, m_valid, m_rep, m_drop;
  int m_key, m_run, m_miss, m_since, m_nrep;
  logic [3:0] m_id;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [31:0] xy(input int x, input int y);
    logic [31:0] v;
    v = {x[15:0], y[15:0]};
    return v;
  endfunction

  // Key index by plain division; -1 for no touch or outside the grid.
  function automatic int model_key(input logic [31:0] s);
    int x, y, col, row;
    x = {16'd0, s[31:16]};
    y = {16'd0, s[15:0]};
    if (s == 32'd0 || x < X0 || y < Y0) return -1;
    col = (x - X0) / W;
    row = (y - Y0) / H;
    if (col >= COLS || row >= ROWS) return -1;
    return row * COLS + col;
  endfunction

  task automatic model_reset();
    m_tq = '0; m_pending = 0; m_active = 0; m_releasing = 0;
    m_valid = 0; m_rep = 0; m_drop = 0; m_id = '0;
    m_key = -1; m_run = 0; m_miss = 0; m_since = 0; m_nrep = 0;
    exp_q.delete();
  endtask

  task automatic model_step(input logic [31:0] t, input bit r);
    logic [31:0] s;
    int k;
    bit match, emit, erep;
    s = m_tq;
    m_tq = t;
    k = model_key(s);
    match = (k >= 0) && (k == m_key);
    emit = 0;
    erep = 0;
    if (!m_active) begin
      if (m_pending) begin
        if (match) m_run++;
        else m_pending = 0;
      end else if (k >= 0) begin
        m_pending = 1; m_key = k; m_run = 1;
      end
      if (m_pending && m_run == DEB) begin
        emit = 1; m_active = 1; m_pending = 0; m_releasing = 0; m_since = 0; m_nrep = 0;
      end
    end else if (m_releasing) begin
      if (match) m_releasing = 0;
      else begin
        m_miss++;
        if (m_miss == DEB) begin m_active = 0; m_releasing = 0; end
      end
    end else if (match) begin
      m_since++;
      if (m_since == ((m_nrep == 0) ? RDLY : RPER)) begin
        emit = 1; erep = 1; m_since = 0; m_nrep++;
      end
    end else begin
      m_releasing = 1; m_miss = 1;
      if (DEB == 1) begin m_active = 0; m_releasing = 0; end
    end
    m_drop = 0;
    if (emit) begin
      if (!m_valid || r) begin
        m_valid = 1; m_id = m_key[3:0]; m_rep = erep;
        exp_q.push_back({erep, m_key[3:0]});
      end else begin
        m_drop = 1;
      end
    end else if (m_valid && r) begin
      m_valid = 0;
    end
  endtask

  // driver: one clock cycle, entered and left at a falling edge
  task automatic cycle(input logic [31:0] t, input bit r);
    logic [4:0] e;
    touch_data = t;
    key_ready = r;
    #1;
    if (key_valid && key_ready) begin
      acc_cnt++;
      last_acc_id = key_id;
      check("sb_pending", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("sb_event", {key_repeat, key_id}, e);
      end
    end
    @(posedge clk);
    if (rstn) model_step(t, r);
    else model_reset();
    #1;
    if (key_drop) drop_cnt++;
    check("key_valid", key_valid, m_valid);
    check("key_drop", key_drop, m_drop);
    check("touch_active", touch_active, m_active);
    if (m_valid) begin
      check("key_id", key_id, m_id);
      check("key_repeat", key_repeat, m_rep);
    end
    @(negedge clk);
  endtask

  task automatic hold(input logic [31:0] t, input int n, input bit r);
    for (int i = 0; i < n; i++) cycle(t, r);
  endtask

  initial begin
    int a0, d0;
    logic [31:0] t;
    model_reset();
    // reset
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", key_valid, 0);
    check("rst_active", touch_active, 0);
    check("rst_drop", key_drop, 0);
    check("rst_id", key_id, 0);
    rstn = 1'b1;
    hold(0, 2, 1);

    // press key 1 with exact latency
    a0 = acc_cnt;
    hold(xy(315, 100), 4, 1);
    check("press1_not_yet", key_valid, 0);
    cycle(xy(315, 100), 1);
    check("press1_valid", key_valid, 1);
    check("press1_id", key_id, 1);
    check("press1_active", touch_active, 1);
    hold(xy(315, 100), 5, 1);
    hold(0, 6, 1);
    check("press1_events", acc_cnt - a0, 1);
    check("press1_released", touch_active, 0);

    // bounce rejection
    a0 = acc_cnt;
    hold(xy(630, 250), 3, 1);
    hold(0, 6, 1);
    check("bounce_events", acc_cnt - a0, 0);
    check("bounce_active", touch_active, 0);
    a0 = acc_cnt;
    hold(xy(630, 250), 6, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1);
      cycle(xy(630, 250), 1);
    end
    hold(0, 8, 1);
    check("dropout_events", acc_cnt - a0, 1);

    // auto-repeat
    a0 = acc_cnt;
    hold(xy(630, 250), 100, 1);
    hold(0, 8, 1);
    check("repeat_events", acc_cnt - a0, 4);
    check("repeat_last_id", last_acc_id, 7);

    // backpressure
    d0 = drop_cnt;
    hold(xy(617, 85), 6, 0);
    hold(0, 6, 0);
    hold(xy(20, 100), 6, 0);
    check("bp_valid", key_valid, 1);
    check("bp_id", key_id, 3);
    check("bp_drops", drop_cnt - d0, 1);
    cycle(0, 1);
    check("bp_cleared", key_valid, 0);
    hold(0, 6, 1);

    // grid edges
    a0 = acc_cnt;
    hold(xy(800, 100), 6, 1); hold(0, 6, 1);
    hold(xy(20, 480), 6, 1); hold(0, 6, 1);
    check("edge_miss_events", acc_cnt - a0, 0);
    hold(xy(799, 479), 6, 1); hold(0, 6, 1);
    check("edge_max_id", last_acc_id, 11);
    hold(xy(0, 1), 6, 1); hold(0, 6, 1);
    check("edge_min_id", last_acc_id, 0);
    check("edge_events", acc_cnt - a0, 2);

    // reset while held
    hold(xy(710, 85), 10, 1);
    check("pre_rst_active", touch_active, 1);
    rstn = 1'b0;
    #1;
    check("midrst_active", touch_active, 0);
    check("midrst_valid", key_valid, 0);
    check("midrst_state", dbg_state, 0);
    a0 = acc_cnt;
    hold(xy(710, 85), 4, 1);
    check("midrst_events", acc_cnt - a0, 0);
    rstn = 1'b1;
    hold(xy(710, 85), 6, 1);
    check("post_rst_events", acc_cnt - a0, 1);
    check("post_rst_id", last_acc_id, 3);
    hold(0, 6, 1);

    // random touch segments
    for (int i = 0; i < 160; i++) begin
      int kind, len, c, r;
      kind = $urandom_range(0, 9);
      c = $urandom_range(0, COLS - 1);
      r = $urandom_range(0, ROWS - 1);
      len = ($urandom_range(0, 9) == 0) ? $urandom_range(55, 80) : $urandom_range(1, 9);
      case (kind)
        6: t = xy(X0 + COLS * W + $urandom_range(0, 300), $urandom_range(0, 500));
        7: t = 0;
        8: t = xy(X0 + c * W, Y0 + (r + 1) * H - 1);
        9: t = xy($urandom_range(0, 900), Y0 + ROWS * H + $urandom_range(0, 50));
        default: t = xy(X0 + c * W + $urandom_range(0, W - 1), Y0 + r * H + $urandom_range(0, H - 1));
      endcase
      for (int j = 0; j < len; j++) cycle(t, $urandom_range(0, 3) != 0);
    end
    hold(0, 10, 1);
    check("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
